sd_pack_c: RTL and testbench

Width-packing stage that sits directly downstream of `sd_fifo_c`. It consumes narrow `width`-bit beats over the srdy/drdy handshake and assembles `ratio` beats into one `width*ratio`-bit word. It presents that word on a registered srdy/drdy producer interface. A `c_last` sideband closes a word early, and a per-beat valid mask on the output marks which lanes of the word are valid.

---
 rtl/sd_pack_c_pkg.sv | 15 +
 rtl/sd_pack_c_output.sv | 45 ++++
 rtl/sd_pack_c.sv | 89 ++++++++
 tb/tb_sd_pack_c.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pack_c_pkg.sv
// Shared helpers for the sd_pack_c width-packing stage.
// Lane-index sizing lives here so the top and the bench agree on it.
package sd_pack_c_pkg;

    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 16;

    // Lane counter width; never narrower than one bit.
    function automatic int lane_idx_bits(input int r);
        int b;
        b = $clog2(r);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/sd_pack_c_output.sv
// Registered srdy/drdy output stage: one word of storage.
// It accepts a new word whenever it is empty or its current word is being taken.
module sd_pack_c_output #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ic_srdy,
    output logic             ic_drdy,
    input  logic [width-1:0] ic_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data
);

    logic             srdy_q, srdy_d;
    logic [width-1:0] data_q, data_d;

    assign ic_drdy = !srdy_q || p_drdy;

    always_comb begin
        srdy_d = srdy_q;
        data_d = data_q;
        if (ic_srdy && ic_drdy) begin
            srdy_d = 1'b1;
            data_d = ic_data;
        end else if (p_drdy) begin
            srdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            srdy_q <= 1'b0;
            data_q <= '0;
        end else begin
            srdy_q <= srdy_d;
            data_q <= data_d;
        end
    end

    assign p_srdy = srdy_q;
    assign p_data = data_q;

endmodule

// File: rtl/sd_pack_c.sv
// Packs `ratio` narrow beats into one wide word; c_last closes a word early.
// The packed word and its lane-valid mask travel together through the output stage.
module sd_pack_c
    import sd_pack_c_pkg::*;
#(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c_srdy,
    output logic                   c_drdy,
    input  logic [width-1:0]       c_data,
    input  logic                   c_last,
    output logic                   p_srdy,
    input  logic                   p_drdy,
    output logic [width*ratio-1:0] p_data,
    output logic [ratio-1:0]       p_mask
);

    localparam int              CNT_W    = lane_idx_bits(ratio);
    localparam int              WORD_W   = width * ratio;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ratio - 1);

    logic [WORD_W-1:0] acc_q, acc_d, word_d;
    logic [ratio-1:0]  acc_mask_q, acc_mask_d, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic close_pending;
    logic accept;
    logic close;
    logic out_drdy;
    logic [WORD_W+ratio-1:0] out_word;

    // A closing beat may only wait on the output register; all others go straight in.
    assign close_pending = (cnt_q == CNT_LAST) || (c_srdy && c_last);
    assign c_drdy        = reset && (!close_pending || out_drdy);
    assign accept        = c_srdy && c_drdy;
    assign close         = accept && close_pending;

    always_comb begin
        word_d                             = acc_q;
        word_d[int'(cnt_q)*width +: width] = c_data;
        mask_d                             = acc_mask_q;
        mask_d[cnt_q]                      = 1'b1;

        acc_d      = acc_q;
        acc_mask_d = acc_mask_q;
        cnt_d      = cnt_q;
        if (accept) begin
            acc_d = word_d;
            if (close) begin
                acc_mask_d = '0;
                cnt_d      = '0;
            end else begin
                acc_mask_d = mask_d;
                cnt_d      = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q      <= '0;
            acc_mask_q <= '0;
            cnt_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            acc_mask_q <= acc_mask_d;
            cnt_q      <= cnt_d;
        end
    end

    sd_pack_c_output #(
        .width (WORD_W + ratio)
    ) u_output (
        .clk     (clk),
        .reset   (reset),
        .ic_srdy (close),
        .ic_drdy (out_drdy),
        .ic_data ({mask_d, word_d}),
        .p_srdy  (p_srdy),
        .p_drdy  (p_drdy),
        .p_data  (out_word)
    );

    assign {p_mask, p_data} = out_word;

endmodule

// File: tb/tb_sd_pack_c.sv
// Self-checking bench for sd_pack_c: directed vector table, hand-written
// backpressure/reset sequences, and a long randomized run against a queue-based model.
module tb_sd_pack_c;

    localparam int W = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           c_srdy = 1'b0;
    logic           c_drdy;
    logic [W-1:0]   c_data = '0;
    logic           c_last = 1'b0;
    logic           p_srdy;
    logic           p_drdy = 1'b0;
    logic [W*R-1:0] p_data;
    logic [R-1:0]   p_mask;

    sd_pack_c #(.width(W), .ratio(R)) dut (
        .clk    (clk),
        .reset  (reset),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .c_last (c_last),
        .p_srdy (p_srdy),
        .p_drdy (p_drdy),
        .p_data (p_data),
        .p_mask (p_mask)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic           s_drdy, s_psrdy;
    logic [W*R-1:0] s_pdata;
    logic [R-1:0]   s_pmask;

    // Reference model: partial word as a queue of beats plus one output slot.
    logic [W-1:0]   part_q[$];
    logic           m_ov;
    logic [W*R-1:0] m_od;
    logic [R-1:0]   m_om;

    typedef struct {
        logic           srdy;
        logic [W-1:0]   data;
        logic           last;
        logic           pd;
        logic           exp_drdy;
        logic           exp_psrdy;
        logic [W*R-1:0] exp_data;
        logic [R-1:0]   exp_mask;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mkv(logic srdy, logic [W-1:0] d, logic last, logic pd,
                                 logic ed, logic eps, logic [W*R-1:0] edat, logic [R-1:0] em);
        vec_t v;
        v.srdy = srdy; v.data = d; v.last = last; v.pd = pd;
        v.exp_drdy = ed; v.exp_psrdy = eps; v.exp_data = edat; v.exp_mask = em;
        return v;
    endfunction

    function automatic logic [W*R-1:0] lmask(logic [R-1:0] m);
        logic [W*R-1:0] r;
        r = '0;
        for (int i = 0; i < R; i++) r[i*W +: W] = {W{m[i]}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic srdy, input logic [W-1:0] d, input logic last, input logic pd);
        @(negedge clk);
        c_srdy = srdy; c_data = d; c_last = last; p_drdy = pd;
        #1;
        s_drdy = c_drdy; s_psrdy = p_srdy; s_pdata = p_data; s_pmask = p_mask;
    endtask

    function automatic void model_clear();
        part_q.delete();
        m_ov = 1'b0; m_od = '0; m_om = '0;
    endfunction

    function automatic logic model_closing(logic srdy, logic last);
        return (part_q.size() == R - 1) || (srdy && last);
    endfunction

    function automatic logic model_drdy(logic srdy, logic last, logic pd);
        return !model_closing(srdy, last) || !m_ov || pd;
    endfunction

    // Returns 1 if the beat was accepted.
    function automatic logic model_step(logic srdy, logic [W-1:0] d, logic last, logic pd);
        logic closing, acc;
        closing = model_closing(srdy, last);
        acc = srdy && model_drdy(srdy, last, pd);
        if (m_ov && pd) m_ov = 1'b0;
        if (acc) begin
            part_q.push_back(d);
            if (closing) begin
                m_od = '0;
                for (int i = 0; i < part_q.size(); i++) m_od[i*W +: W] = part_q[i];
                m_om = R'((1 << part_q.size()) - 1);
                m_ov = 1'b1;
                part_q.delete();
            end
        end
        return acc;
    endfunction

    task automatic model_check(input string tag);
        chk({tag, "_drdy"},  s_drdy,  model_drdy(c_srdy, c_last, p_drdy));
        chk({tag, "_psrdy"}, s_psrdy, m_ov);
        if (m_ov) begin
            chk({tag, "_mask"}, s_pmask, m_om);
            chk({tag, "_data"}, s_pdata & lmask(m_om), m_od);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; c_srdy = 1'b0; c_last = 1'b0; p_drdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    logic [W*R-1:0] held;
    logic [7:0]     pa, pb;
    logic           acc;
    int             beats, cyc;
    logic           rs, rl, rp;

    initial begin
        // Reset state, with an eager upstream trying to push a closing beat.
        reset = 1'b0; c_srdy = 1'b1; c_last = 1'b1; c_data = 8'h55; p_drdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_drdy", c_drdy, 1'b0);
        chk("rst_psrdy", p_srdy, 1'b0);
        chk("rst_pdata", p_data, '0);
        chk("rst_pmask", p_mask, '0);

        // Directed vectors: full words, early close, single-beat close.
        do_reset();
        tbl[0]  = mkv(1, 8'h01, 0, 1, 1, 0, '0, '0);
        tbl[1]  = mkv(1, 8'h02, 0, 1, 1, 0, '0, '0);
        tbl[2]  = mkv(1, 8'h03, 0, 1, 1, 0, '0, '0);
        tbl[3]  = mkv(1, 8'h04, 0, 1, 1, 0, '0, '0);
        tbl[4]  = mkv(1, 8'h05, 0, 1, 1, 1, 32'h04030201, 4'hF);
        tbl[5]  = mkv(1, 8'h06, 0, 1, 1, 0, '0, '0);
        tbl[6]  = mkv(1, 8'h07, 0, 1, 1, 0, '0, '0);
        tbl[7]  = mkv(1, 8'h08, 0, 1, 1, 0, '0, '0);
        tbl[8]  = mkv(0, 8'h00, 0, 1, 1, 1, 32'h08070605, 4'hF);
        tbl[9]  = mkv(1, 8'h11, 0, 1, 1, 0, '0, '0);
        tbl[10] = mkv(1, 8'h22, 1, 1, 1, 0, '0, '0);
        tbl[11] = mkv(1, 8'h33, 1, 1, 1, 1, 32'h00002211, 4'h3);
        tbl[12] = mkv(1, 8'h7E, 1, 1, 1, 1, 32'h00000033, 4'h1);
        tbl[13] = mkv(0, 8'h00, 0, 1, 1, 1, 32'h0000007E, 4'h1);
        tbl[14] = mkv(0, 8'h00, 0, 1, 1, 0, '0, '0);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].srdy, tbl[i].data, tbl[i].last, tbl[i].pd);
            chk($sformatf("vec%0d_drdy", i), s_drdy, tbl[i].exp_drdy);
            chk($sformatf("vec%0d_psrdy", i), s_psrdy, tbl[i].exp_psrdy);
            if (tbl[i].exp_psrdy) begin
                chk($sformatf("vec%0d_mask", i), s_pmask, tbl[i].exp_mask);
                chk($sformatf("vec%0d_data", i), s_pdata & lmask(tbl[i].exp_mask),
                    tbl[i].exp_data & lmask(tbl[i].exp_mask));
            end
        end

        // Backpressure: one full word held, three more absorbed, closing beat stalls.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hB0 + 8'(i), 0, 0);
            chk($sformatf("bp_fill%0d_drdy", i), s_drdy, 1'b1);
        end
        held = 32'hB3B2B1B0;
        for (int i = 4; i < 7; i++) begin
            drive(1, 8'hB0 + 8'(i), 0, 0);
            chk($sformatf("bp_abs%0d_drdy", i), s_drdy, 1'b1);
            chk($sformatf("bp_abs%0d_psrdy", i), s_psrdy, 1'b1);
            chk($sformatf("bp_abs%0d_data", i), s_pdata, held);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 8'hB7, 0, 0);
            chk($sformatf("bp_stall%0d_drdy", i), s_drdy, 1'b0);
            chk($sformatf("bp_stall%0d_data", i), s_pdata, held);
            chk($sformatf("bp_stall%0d_mask", i), s_pmask, 4'hF);
        end
        drive(1, 8'hB7, 0, 1);
        chk("bp_rel_drdy", s_drdy, 1'b1);
        chk("bp_rel_data", s_pdata, held);
        drive(0, 8'h00, 0, 1);
        chk("bp_next_psrdy", s_psrdy, 1'b1);
        chk("bp_next_data", s_pdata, 32'hB7B6B5B4);
        chk("bp_next_mask", s_pmask, 4'hF);
        drive(0, 8'h00, 0, 1);
        chk("bp_empty_psrdy", s_psrdy, 1'b0);

        // Reset in the middle of a word: partial beats are discarded.
        do_reset();
        drive(1, 8'hC0, 0, 1);
        drive(1, 8'hC1, 0, 1);
        @(negedge clk);
        reset = 1'b0; c_srdy = 1'b1; c_data = 8'hC2; c_last = 1'b1;
        #1;
        chk("mid_rst_drdy", c_drdy, 1'b0);
        @(negedge clk); #1;
        chk("mid_rst_psrdy", p_srdy, 1'b0);
        chk("mid_rst_pdata", p_data, '0);
        chk("mid_rst_pmask", p_mask, '0);
        c_srdy = 1'b0; c_last = 1'b0;
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) drive(1, 8'hA0 + 8'(i), 0, 1);
        drive(0, 8'h00, 0, 1);
        chk("mid_rst_psrdy2", s_psrdy, 1'b1);
        chk("mid_rst_data2", s_pdata, 32'hA3A2A1A0);
        chk("mid_rst_mask2", s_pmask, 4'hF);

        // Randomized run against the model: fixed patterns first, then random.
        do_reset();
        pa = 8'h5A; pb = 8'hA5;
        beats = 0; cyc = 0;
        while (beats < 9000 && cyc < 60000) begin
            if (cyc < 3000) begin
                rs = pa[cyc % 8];
                rp = pb[cyc % 8];
            end else begin
                rs = ($urandom_range(0, 3) != 0);
                rp = ($urandom_range(0, 2) != 0);
            end
            rl = ($urandom_range(0, 5) == 0);
            drive(rs, beats[W-1:0], rl, rp);
            model_check("rnd");
            acc = model_step(rs, beats[W-1:0], rl, rp);
            if (acc) beats++;
            cyc++;
        end
        chk("rnd_beats_done", beats >= 9000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
